// File: rtl/button_repeat.sv
// button_repeat: turns a debounced button level into paddle-step strobes.
// A press gives one strobe. Holding the button gives another strobe after
// INIT_DELAY cycles, then one every REPEAT_PERIOD cycles until release.
// Optional feature macro: RELEASE_PULSE_EN adds a one-cycle release_pulse
// output when a tracked press is released.
module button_repeat #(
  parameter int INIT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic enable,
  output logic step,
  output logic held
`ifdef RELEASE_PULSE_EN
  ,
  output logic release_pulse
`endif
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_q, step_d;
  logic               held_q, held_d;
  logic               btn_q;
  logic               rise;

  // btn_q resets high so a button held through reset never looks like a press.
  assign rise = btn & ~btn_q;

  // State, counter, registered outputs and the button history register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      held_q  <= 1'b0;
      btn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      held_q  <= held_d;
      btn_q   <= btn;
    end
  end

  // Next-state logic: release or disable always wins over a terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && rise) begin
          step_d  = 1'b1;
          cnt_d   = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (!btn || !enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == INIT_LAST) begin
          step_d  = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!btn || !enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_LAST) begin
          step_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  assign step = step_q;
  assign held = held_q;

`ifdef RELEASE_PULSE_EN
  logic fall;
  logic rel_q;

  assign fall = ~btn & btn_q;

  // Pulse only when a press is still being tracked; a disabled FSM is silent.
  always_ff @(posedge clk) begin
    if (!rst_n) rel_q <= 1'b0;
    else        rel_q <= fall && (state_q != IDLE);
  end

  assign release_pulse = rel_q;
`endif

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench for button_repeat with INIT_DELAY=4, REPEAT_PERIOD=3.
module tb_button_repeat;
  logic clk = 1'b0;
  logic rst_n, btn, enable;
  logic step, held;
`ifdef RELEASE_PULSE_EN
  logic release_pulse;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_repeat #(.INIT_DELAY(4), .REPEAT_PERIOD(3), .CNT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .enable (enable),
    .step   (step),
    .held   (held)
`ifdef RELEASE_PULSE_EN
    ,
    .release_pulse(release_pulse)
`endif
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Apply inputs, let one posedge sample them, then check outputs 1 time unit later.
  task automatic cyc(input string tag, input logic b, input logic e,
                     input logic es, input logic eh, input logic er = 1'b0);
    btn    = b;
    enable = e;
    @(posedge clk);
    #1;
    chk({tag, ".step"}, step, es);
    chk({tag, ".held"}, held, eh);
`ifdef RELEASE_PULSE_EN
    chk({tag, ".rel"}, release_pulse, er);
`endif
  endtask

  initial begin
    rst_n = 1'b0; btn = 1'b1; enable = 1'b1;
    // reset with the button held
    cyc("rst0", 1, 1, 0, 0);
    cyc("rst1", 1, 1, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc("held_thru_rst", 1, 1, 0, 0);
    cyc("gap0", 0, 1, 0, 0);

    // tap: btn high on k0, k0+1
    cyc("tap_k0", 1, 1, 1, 1);
    cyc("tap_k1", 1, 1, 0, 1);
    cyc("tap_k2", 0, 1, 0, 0, 1);
    cyc("tap_k3", 0, 1, 0, 0);

    // long hold k0..k0+11: strobes at 0,4,7,10
    for (int i = 0; i < 12; i++)
      cyc($sformatf("hold_k%0d", i), 1, 1, (i == 0 || i == 4 || i == 7 || i == 10), 1);
    cyc("hold_rel", 0, 1, 0, 0, 1);
    cyc("hold_gap", 0, 1, 0, 0);

    // release exactly on the first terminal count
    cyc("drop_k0", 1, 1, 1, 1);
    for (int i = 1; i < 4; i++) cyc($sformatf("drop_k%0d", i), 1, 1, 0, 1);
    cyc("drop_k4", 0, 1, 0, 0, 1);
    cyc("drop_k5", 0, 1, 0, 0);

    // release on a repeat terminal count (k0+7)
    cyc("rterm_k0", 1, 1, 1, 1);
    for (int i = 1; i < 7; i++) cyc($sformatf("rterm_k%0d", i), 1, 1, (i == 4), 1);
    cyc("rterm_k7", 0, 1, 0, 0, 1);
    cyc("rterm_gap", 0, 1, 0, 0);

    // enable dropped mid-hold, reasserted with btn still high
    cyc("en_k0", 1, 1, 1, 1);
    cyc("en_k1", 1, 1, 0, 1);
    cyc("en_k2", 1, 0, 0, 0);
    cyc("en_k3", 1, 0, 0, 0);
    cyc("en_k4", 1, 0, 0, 0);
    for (int i = 5; i <= 12; i++) cyc($sformatf("en_k%0d", i), 1, 1, 0, 0);
    cyc("en_low", 0, 1, 0, 0);
    cyc("en_repress", 1, 1, 1, 1);
    cyc("en_repress1", 1, 1, 0, 1);
    cyc("en_rel", 0, 1, 0, 0, 1);
    cyc("en_gap", 0, 1, 0, 0);

    // press while disabled is ignored
    cyc("dis_press", 1, 0, 0, 0);
    cyc("dis_hold", 1, 0, 0, 0);
    cyc("dis_low", 0, 0, 0, 0);

    // 3-cycle tap: one step, one release pulse
    cyc("tap3_k0", 1, 1, 1, 1);
    cyc("tap3_k1", 1, 1, 0, 1);
    cyc("tap3_k2", 1, 1, 0, 1);
    cyc("tap3_k3", 0, 1, 0, 0, 1);
    cyc("tap3_k4", 0, 1, 0, 0, 0);

    // enable dropped before release: no release pulse
    cyc("nrel_k0", 1, 1, 1, 1);
    cyc("nrel_k1", 1, 0, 0, 0);
    cyc("nrel_k2", 0, 0, 0, 0, 0);
    cyc("nrel_k3", 0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
